// File: rtl/fetch_queue_riscv.sv
// -----------------------------------------------------------------------------
// fetch_queue_riscv
//
// Instruction-fetch front end for the single-cycle decode/execute datapath.
// It owns the fetch PC and drives a 1-cycle-latency instruction memory. It
// buffers returned words with their PCs in a small FIFO, and presents the
// head entry to the decoder through a valid/ready handshake. A redirect from
// execute flushes everything that is buffered or in flight and restarts fetch
// at the target.
//
// Ports
//   clk            system clock, all state updates on posedge
//   rst            synchronous active-high reset
//   imem_req       read request to instruction memory this cycle
//   imem_addr      read address (current fetch PC)
//   imem_rdata     instruction word, valid the cycle after imem_req
//   redirect_en    taken branch/jump from execute
//   redirect_addr  redirect target
//   out_valid      out_instr/out_pc hold a valid entry
//   out_ready      decoder consumes the head entry
//   out_instr      head instruction
//   out_pc         PC of the head instruction
//   misalign_err   one-cycle pulse: last redirect target was not 4-byte aligned
//   occupancy      current FIFO entry count
// -----------------------------------------------------------------------------
module fetch_queue_riscv #(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                  DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req,
    output logic [PC_WIDTH-1:0]     imem_addr,
    input  logic [31:0]             imem_rdata,
    input  logic                    redirect_en,
    input  logic [PC_WIDTH-1:0]     redirect_addr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_instr,
    output logic [PC_WIDTH-1:0]     out_pc,
    output logic                    misalign_err,
    output logic [$clog2(DEPTH):0]  occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0]       DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]       CNT_ONE = CW'(1);
    localparam logic [AW-1:0]       PTR_ONE = AW'(1);
    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

    // Control state (reset)
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                inflight_q, inflight_d;
    logic [AW-1:0]       wptr_q, wptr_d;
    logic [AW-1:0]       rptr_q, rptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                misalign_q, misalign_d;

    // Data state (no reset)
    logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [PC_WIDTH-1:0] pc_mem_q    [DEPTH];
    logic [31:0]         instr_mem_q [DEPTH];

    logic issue;
    logic push;
    logic pop;

    // Stage 0: request issue. A pop in the same cycle is not credited, so
    // count + inflight < DEPTH always leaves room for the response.
    assign issue = !rst && !redirect_en && ((count_q + CW'(inflight_q)) < DEPTH_C);

    // Stage 1: response capture. A redirect or reset kills the in-flight word.
    assign push  = !rst && !redirect_en && inflight_q;

    assign out_valid = !rst && (count_q != '0);
    // A pop during a redirect is moot: the whole FIFO is being flushed.
    assign pop       = out_valid && out_ready && !redirect_en;

    assign imem_req     = issue;
    assign imem_addr    = fetch_pc_q;
    assign out_instr    = instr_mem_q[rptr_q];
    assign out_pc       = pc_mem_q[rptr_q];
    assign misalign_err = misalign_q;
    assign occupancy    = count_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        count_d       = count_q;
        misalign_d    = 1'b0;

        if (redirect_en) begin
            // Low address bits are dropped; the misalignment is only reported.
            fetch_pc_d = {redirect_addr[PC_WIDTH-1:2], 2'b00};
            inflight_d = 1'b0;
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            misalign_d = |redirect_addr[1:0];
        end else begin
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + PC_STEP;
                inflight_pc_d = fetch_pc_q;
            end
            if (push) wptr_d = wptr_q + PTR_ONE;
            if (pop)  rptr_d = rptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    // Stage 2: FIFO storage, written at the response edge.
    always_ff @(posedge clk) begin
        inflight_pc_q <= inflight_pc_d;
        if (push) begin
            pc_mem_q[wptr_q]    <= inflight_pc_q;
            instr_mem_q[wptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_queue_riscv.sv
module tb_fetch_queue_riscv;

    localparam int          PCW = 64;
    // Memory word is the address tagged with a constant so pc and instr differ.
    localparam logic [31:0] TAG = 32'h5A5A_0000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            imem_req;
    logic [PCW-1:0]  imem_addr;
    logic [31:0]     imem_rdata = '0;
    logic            redirect_en = 1'b0;
    logic [PCW-1:0]  redirect_addr = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     out_instr;
    logic [PCW-1:0]  out_pc;
    logic            misalign_err;
    logic [2:0]      occupancy;

    int n_cmp = 0;
    int n_err = 0;
    logic [PCW-1:0] sb [$];

    fetch_queue_riscv #(.PC_WIDTH(PCW), .RESET_PC(64'h0), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_en(redirect_en), .redirect_addr(redirect_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .misalign_err(misalign_err), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // 1-cycle-latency instruction memory.
    always @(posedge clk) imem_rdata <= imem_addr[31:0] ^ TAG;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [63:0] start, input int n);
        for (int i = 0; i < n; i++) sb.push_back(start + 64'(4 * i));
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) tick();
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_occ(input logic [2:0] n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (occupancy == n) break;
        end
        chk("occ_wait", 64'(occupancy), 64'(n));
    endtask

    // Scoreboard: every accepted handshake is compared in order.
    always @(negedge clk) begin
        if (!rst && !redirect_en && out_valid && out_ready && sb.size() != 0) begin
            logic [63:0] e;
            e = sb.pop_front();
            chk("out_pc", out_pc, e);
            chk("out_instr", 64'(out_instr), 64'(e[31:0] ^ TAG));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout n_cmp=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state and first-fetch latency, streaming at full rate
        out_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_mis", 64'(misalign_err), 64'd0);
        tick();
        push_seq(64'h0, 4);
        rst = 1'b0;
        @(negedge clk);
        chk("req_after_rst", 64'(imem_req), 64'd1);
        chk("lat_c0", 64'(out_valid), 64'd0);
        tick(); @(negedge clk);
        chk("lat_c1", 64'(out_valid), 64'd0);
        tick(); @(negedge clk);
        chk("lat_c2", 64'(out_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick(); @(negedge clk);
            chk("stream_valid", 64'(out_valid), 64'd1);
        end
        wait_drain(10);

        // Back-pressure: FIFO fills to DEPTH, then drains in order
        tick();
        sb.delete();
        rst = 1'b1; out_ready = 1'b0;
        tick(); tick();
        push_seq(64'h0, 6);
        rst = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        chk("full_occ", 64'(occupancy), 64'd4);
        chk("full_req", 64'(imem_req), 64'd0);
        chk("full_valid", 64'(out_valid), 64'd1);
        tick();
        out_ready = 1'b1;
        wait_drain(20);

        // Redirect with 3 buffered and one in flight
        tick();
        sb.delete();
        rst = 1'b1; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        wait_occ(3'd3, 20);
        redirect_en = 1'b1; redirect_addr = 64'h100;
        sb.delete();
        push_seq(64'h100, 3);
        #1;
        chk("redir_req", 64'(imem_req), 64'd0);
        tick();
        redirect_en = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("redir_valid0", 64'(out_valid), 64'd0);
        chk("redir_occ", 64'(occupancy), 64'd0);
        chk("redir_addr", imem_addr, 64'h100);
        tick(); @(negedge clk);
        chk("redir_valid1", 64'(out_valid), 64'd0);
        tick(); @(negedge clk);
        chk("redir_valid2", 64'(out_valid), 64'd1);
        wait_drain(10);

        // Misaligned redirect
        tick();
        redirect_en = 1'b1; redirect_addr = 64'h102;
        sb.delete();
        push_seq(64'h100, 2);
        @(negedge clk);
        chk("mis_before", 64'(misalign_err), 64'd0);
        tick();
        redirect_en = 1'b0;
        @(negedge clk);
        chk("mis_pulse", 64'(misalign_err), 64'd1);
        tick(); @(negedge clk);
        chk("mis_after", 64'(misalign_err), 64'd0);
        wait_drain(10);

        // Back-to-back redirects: the last one wins
        tick();
        redirect_en = 1'b1; redirect_addr = 64'h200;
        sb.delete();
        tick();
        redirect_addr = 64'h300;
        sb.delete();
        push_seq(64'h300, 2);
        tick();
        redirect_en = 1'b0;
        wait_drain(10);

        // PC wrap-around
        tick();
        redirect_en = 1'b1; redirect_addr = 64'hFFFF_FFFF_FFFF_FFF8;
        sb.delete();
        sb.push_back(64'hFFFF_FFFF_FFFF_FFF8);
        sb.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        sb.push_back(64'h0);
        sb.push_back(64'h4);
        tick();
        redirect_en = 1'b0;
        wait_drain(12);

        // Reset with 2 buffered and one in flight
        tick();
        out_ready = 1'b0;
        redirect_en = 1'b1; redirect_addr = 64'h40;
        sb.delete();
        tick();
        redirect_en = 1'b0;
        wait_occ(3'd2, 20);
        rst = 1'b1;
        sb.delete();
        push_seq(64'h0, 3);
        tick();
        @(negedge clk);
        chk("rst2_valid", 64'(out_valid), 64'd0);
        chk("rst2_occ", 64'(occupancy), 64'd0);
        chk("rst2_addr", imem_addr, 64'h0);
        tick();
        rst = 1'b0; out_ready = 1'b1;
        wait_drain(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
